// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader.
package prog_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      WAIT_WORD,
      STROBE_HI,
      STROBE_LO,
      DONE,
      ERR
   } state_t;

   localparam int WORD_W        = 16;
   localparam int MAX_WORDS_DEF = 8;
   localparam int TMR_W         = 8;

endpackage

// File: rtl/prog_loader_strobe_timer.sv
// Loadable down-counter that times the clear and strobe phases of the loader.
module strobe_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ld,
   input  logic [W-1:0] ld_val,
   output logic         expired
);

   logic [W-1:0] cnt;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst)
         cnt <= '0;
      else if (ld)
         cnt <= ld_val;
      else if (cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign expired = (cnt == '0);

endmodule

// File: rtl/prog_loader.sv
// Program loader: streams words into a program memory write port with timed strobes.
// Optional checksum output enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int CLR_CYCLES = 2,
   parameter int NXT_HI     = 4,
   parameter int NXT_LO     = 4,
   parameter int MAX_WORDS  = MAX_WORDS_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              src_valid,
   input  logic [WORD_W-1:0] src_data,
   input  logic              src_last,
   output logic              src_ready,
   output logic [WORD_W-1:0] inp_data,
   output logic              clear,
   output logic              load,
   output logic              nxt,
   output logic              status_ok,
   output logic [3:0]        words_loaded,
   output logic              busy,
   output logic              err
`ifdef PROG_LOADER_CHECKSUM_EN
   ,
   output logic [WORD_W-1:0] chk
`endif
);

   // Timer holds N-1 so the phase lasts exactly N cycles including the expiry cycle.
   localparam logic [TMR_W-1:0] CLR_LD = TMR_W'(CLR_CYCLES - 1);
   localparam logic [TMR_W-1:0] HI_LD  = TMR_W'(NXT_HI - 1);
   localparam logic [TMR_W-1:0] LO_LD  = TMR_W'(NXT_LO - 1);
   localparam logic [3:0]       MAX_CNT = 4'(MAX_WORDS);

   state_t             state, state_nxt;
   logic               tmr_ld;
   logic [TMR_W-1:0]   tmr_val;
   logic               tmr_exp;
   logic               last_flag;

   strobe_timer #(.W(TMR_W)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .ld      (tmr_ld),
      .ld_val  (tmr_val),
      .expired (tmr_exp)
   );

   always_ff @(posedge clk) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      tmr_ld    = 1'b0;
      tmr_val   = '0;
      clear     = 1'b0;
      load      = 1'b0;
      nxt       = 1'b0;
      src_ready = 1'b0;
      status_ok = 1'b0;
      busy      = 1'b0;
      err       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = CLEAR;
               tmr_ld    = 1'b1;
               tmr_val   = CLR_LD;
            end
         end
         CLEAR: begin
            clear = 1'b1;
            busy  = 1'b1;
            if (tmr_exp)
               state_nxt = WAIT_WORD;
         end
         WAIT_WORD: begin
            load      = 1'b1;
            busy      = 1'b1;
            src_ready = 1'b1;
            if (src_valid) begin
               if (words_loaded == MAX_CNT) begin
                  state_nxt = ERR;
               end else begin
                  state_nxt = STROBE_HI;
                  tmr_ld    = 1'b1;
                  tmr_val   = HI_LD;
               end
            end
         end
         STROBE_HI: begin
            load = 1'b1;
            busy = 1'b1;
            nxt  = 1'b1;
            if (tmr_exp) begin
               state_nxt = STROBE_LO;
               tmr_ld    = 1'b1;
               tmr_val   = LO_LD;
            end
         end
         STROBE_LO: begin
            load = 1'b1;
            busy = 1'b1;
            if (tmr_exp)
               state_nxt = last_flag ? DONE : WAIT_WORD;
         end
         DONE, ERR: begin
            status_ok = (state == DONE);
            err       = (state == ERR);
            if (start) begin
               state_nxt = CLEAR;
               tmr_ld    = 1'b1;
               tmr_val   = CLR_LD;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         inp_data     <= '0;
         last_flag    <= 1'b0;
         words_loaded <= '0;
      end else begin
         if (state == CLEAR) begin
            words_loaded <= '0;
            last_flag    <= 1'b0;
         end
         if (state == WAIT_WORD && src_valid) begin
            inp_data  <= src_data;
            last_flag <= src_last;
         end
         // Count only once the high phase completes, so an interrupted strobe never counts.
         if (state == STROBE_HI && tmr_exp)
            words_loaded <= words_loaded + 1'b1;
      end
   end

`ifdef PROG_LOADER_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (!rst)
         chk <= '0;
      else if (state == CLEAR)
         chk <= '0;
      else if (state == STROBE_HI && tmr_exp)
         chk <= chk ^ inp_data;
   end
`endif

endmodule
